// File: rtl/maddu_unit.sv
// Iterative unsigned multiply-accumulate for maddu: {HI,LO} += rs*rt via a radix-2 shift-add loop.
// Owns the architectural HI/LO registers and the mthi/mtlo write path.
module maddu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Carry out of HI is intentionally dropped: the sum wraps modulo 2^(2*WIDTH).
    function automatic logic [2*WIDTH-1:0] acc_wrap(input logic [2*WIDTH-1:0] hilo,
                                                    input logic [2*WIDTH-1:0] p);
        return hilo + p;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi_q <= hilo_wdata;
                    if (lo_we) lo_q <= hilo_wdata;
                    if (start && !flush) begin
                        mcand  <= {{WIDTH{1'b0}}, rs_data};
                        mplier <= rt_data;
                        prod   <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + CW'(1);
                        if (count == CW'(WIDTH - 1)) state <= ACC;
                    end
                end
                ACC: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!flush) begin
                        {hi_q, lo_q} <= acc_wrap({hi_q, lo_q}, prod);
                        done         <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_maddu_unit.sv
// Directed bench for maddu_unit: latency, accumulate wrap, flush, reset abort and write/start ordering.
module tb_maddu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    maddu_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Drive a write of HI/LO in IDLE; returns at the negedge after the edge.
    task automatic wr(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        hi_we = h; lo_we = l; hilo_wdata = d;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Issue start at E0 (any hi_we/lo_we set beforehand ride along); returns at negedge after E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Continue from edge n0 until done, then check latency, busy profile and pulse width.
    task automatic wait_done(input string tag, input int n0);
        int  n;
        logic busy_bad;
        n = n0;
        busy_bad = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (!busy) busy_bad = 1'b1;
        end
        check({tag, "_lat"}, 64'(n), 64'd33);
        check({tag, "_busy_during"}, 64'(busy_bad), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; flush = 1'b0;
        rs_data = '0; rt_data = '0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_hilo", {hi_out, lo_out}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b1;

        // Basic 3*5
        issue(32'd3, 32'd5);
        check("basic_busy_e0", 64'(busy), 64'd1);
        wait_done("basic", 0);
        check("basic_hilo", {hi_out, lo_out}, 64'd15);

        // Preload all ones, then +1 wraps to zero
        wr(1'b1, 1'b1, 32'hFFFF_FFFF);
        check("preload", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(32'd1, 32'd1);
        wait_done("wrap", 0);
        check("wrap_hilo", {hi_out, lo_out}, 64'd0);

        // Max operands
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("max", 0);
        check("max_hilo", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);

        // Flush at E10
        wr(1'b1, 1'b1, 32'd0);
        wr(1'b0, 1'b1, 32'd7);
        issue(32'd2, 32'd4);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        no_done("flush_no_done", 30);
        check("flush_hilo", {hi_out, lo_out}, 64'd7);
        issue(32'd2, 32'd4);
        wait_done("reissue", 0);
        check("reissue_hilo", {hi_out, lo_out}, 64'd15);

        // flush with start in IDLE: nothing starts
        @(negedge clk);
        rs_data = 32'd9; rt_data = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", 64'(busy), 64'd0);
        no_done("idle_flush_no_done", 40);
        check("idle_flush_hilo", {hi_out, lo_out}, 64'd15);

        // Re-start and HI write at E5 are ignored: 15 + 6*7 = 57
        issue(32'd6, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; rs_data = 32'd100; rt_data = 32'd100;
        hi_we = 1'b1; hilo_wdata = 32'h0000_AAAA;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        wait_done("abuse", 5);
        check("abuse_hilo", {hi_out, lo_out}, 64'd57);

        // Async reset at E20 aborts
        issue(32'd3, 32'd3);
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_hilo", {hi_out, lo_out}, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        no_done("arst_no_done", 40);
        check("arst_hilo_hold", {hi_out, lo_out}, 64'd0);

        // LO write together with start: 100 + 2*3 = 106
        @(negedge clk);
        lo_we = 1'b1; hilo_wdata = 32'd100;
        issue(32'd2, 32'd3);
        check("wrstart_lo_e0", 64'(lo_out), 64'd100);
        wait_done("wrstart", 0);
        check("wrstart_hilo", {hi_out, lo_out}, 64'd106);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maddu_unit.md
Name: maddu_unit

Overview:
- Multi-cycle execute-stage responder for the maddu opcode (6'd28). The main decoder marks maddu with regwrite=0 and ALUop=2'b10; this block carries out the operation.
- Computes {HI,LO} <= {HI,LO} + rs*rt, unsigned, using an iterative radix-2 shift-add multiplier.
- Holds the architectural HI/LO registers, supports direct HI/LO writes (mthi/mtlo), and raises a stall to the pipeline while busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each, and the product is 2*WIDTH bits.

Ports:
- clk      in   1      rising-edge clock
- rst      in   1      asynchronous, active-low reset
- start    in   1      EX-stage maddu issue; sampled only in IDLE
- flush    in   1      pipeline flush; aborts an in-flight operation
- rs_data  in   WIDTH  multiplicand
- rt_data  in   WIDTH  multiplier
- hi_we    in   1      direct HI write (mthi)
- lo_we    in   1      direct LO write (mtlo)
- hilo_wdata in WIDTH  data for hi_we / lo_we
- hi_out   out  WIDTH  current HI register
- lo_out   out  WIDTH  current LO register
- busy     out  1      operation in flight; the pipeline stalls on this
- done     out  1      one-cycle pulse: HI/LO have just been updated

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; HI=0, LO=0; busy=0, done=0.
  - Multiplicand, multiplier, partial-product and counter registers all cleared.
  - Reset asserted mid-operation discards the operation; no done pulse is produced.
- States:
  - IDLE: waits for start.
  - MUL: 32 iterations (WIDTH in general).
  - ACC: one cycle.
- IDLE -> MUL, at edge E0 when start=1 and flush=0:
  - Latch rs_data and rt_data, zero-extended to 2*WIDTH.
  - Clear the product register; count=0; busy<=1.
- MUL, each edge E1..E32:
  - If multiplier[0]=1, add the multiplicand to the product.
  - Shift the multiplicand left by 1 and the multiplier right by 1; count++.
  - After the edge where count reaches WIDTH, go to ACC.
- ACC, edge E33:
  - {HI,LO} <= {HI,LO} + product, modulo 2^(2*WIDTH); the carry out of HI is discarded.
  - done<=1, busy<=0, state<=IDLE.
- Edge E34: done<=0. done is high for exactly one cycle.
- Latency: start sampled at E0; HI/LO valid and done=1 after E33.
  - busy is high from after E0 through E32 and low after E33.
  - A new start can be sampled at E33 only if the pipeline re-issues; start is ignored in ACC, so the earliest accepted new start is at E34.
- start while busy (MUL/ACC): ignored.
- flush in MUL or ACC: return to IDLE at that edge, busy<=0, no done pulse, HI/LO unchanged.
  - A flush at the ACC edge also suppresses the accumulate.
- flush and start together in IDLE: flush wins; no operation starts.
- hi_we/lo_we:
  - Honoured only in IDLE (including the start edge E0); ignored in MUL/ACC.
  - Both may be set together; both registers then take hilo_wdata.
  - A write at E0 together with start is applied at E0, so the later accumulate uses the written value.
- hi_out/lo_out are direct register outputs with no bypass; a write becomes visible the cycle after the edge.
- All arithmetic is unsigned.

Test Plan:
- Basic MAC: reset; rs=3, rt=5, start at E0 -> busy high E0..E32, done pulse after E33 for one cycle; HI=0, LO=15.
- Accumulate and wrap:
  - Preload HI=FFFFFFFF, LO=FFFFFFFF via hi_we/lo_we.
  - Then rs=1, rt=1 -> HI=0, LO=0 after E33; the carry is dropped.
- Max operands: HI=LO=0, rs=rt=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- Flush mid-op:
  - Preload LO=7, start rs=2, rt=4, flush at E10 -> busy=0 after E10, no done, LO stays 7.
  - A new start then yields LO=15.
- Protocol abuse:
  - start pulsed again at E5 and hi_we=1 with wdata=AAAA at E5 -> both ignored; the result equals the single-operation value.
  - Reset at E20 -> HI=LO=0, busy=0 immediately, no done.
- Write+start at E0: lo_we=1 with wdata=100 and start rs=2, rt=3 at the same edge -> LO=106 after E33.
